// File: rtl/axi_slave_mem_param_if.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_param_if
// AXI bus bundle between a master and the axi_slave_mem_param terminal memory.
//   AW : awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid / awready
//   W  : wid, wdata, wstrb, wlast, wvalid / wready
//   B  : bid, bresp, bvalid / bready
//   AR : arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid / arready
//   R  : rid, rdata, rresp, rlast, rvalid / rready
// Modports: master (drives requests), slave (drives responses).
// ---------------------------------------------------------------------------
interface axi_slave_mem_param_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 40,
    parameter int ID_W   = 8
);
    // write address
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    // write data
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // write response
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // read address
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    // read data
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_slave_mem_param.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_param
// Behavioural AXI slave memory with independent read and write state
// machines, so one read burst and one write burst may be in flight together.
// FIXED / INCR / WRAP bursts of 1..256 beats at any legal size.
//
// Ports:
//   pll_core_cpuclk : clock, all logic on the rising edge
//   pad_cpu_rst_b   : asynchronous active-low reset (aborts both FSMs)
//   bus             : axi_slave_mem_param_if.slave (AW/W/B/AR/R channels)
//                     wid, wlast, awcache/awprot, arcache/arprot are ignored.
//
// Optional feature macro: AXI_SLV_MEM_OOR_ERR_EN
//   defined   : beats addressing above the memory return SLVERR (write is
//               suppressed, read data is zero).
//   undefined : upper address bits alias onto the memory, responses OKAY.
// ---------------------------------------------------------------------------
module axi_slave_mem_param #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 40,
    parameter int ID_W   = 8,
    parameter int MEM_AW = 15
) (
    input logic                  pll_core_cpuclk,
    input logic                  pad_cpu_rst_b,
    axi_slave_mem_param_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Address of the beat following 'addr'. WRAP is only honoured for the
    // legal lengths 2/4/8/16 beats; everything else (incl. burst 2'b11)
    // behaves as INCR, which also re-aligns an unaligned start address.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] size_mask;
        logic [ADDR_W-1:0] wrap_mask;
        logic [ADDR_W-1:0] aligned_next;
        logic              wrap_ok;
        step         = ADDR_W'(1) << size;
        size_mask    = step - ADDR_W'(1);
        wrap_mask    = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        aligned_next = (addr & ~size_mask) + step;
        wrap_ok      = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_ok) begin
            // stay inside the window, low bits roll over to its base
            next_addr = (addr & ~wrap_mask) | (aligned_next & wrap_mask);
        end else begin
            next_addr = aligned_next;
        end
    endfunction

    // ------------------------------------------------------------------
    // handshakes
    // ------------------------------------------------------------------
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    // write side registers
    wr_state_t         r_w_state;
    logic [ADDR_W-1:0] r_w_addr;
    logic [7:0]        r_aw_len;
    logic [2:0]        r_aw_size;
    logic [1:0]        r_aw_burst;
    logic [7:0]        r_w_cnt;
    logic              r_w_err;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;

    // read side registers
    rd_state_t         r_r_state;
    logic [ADDR_W-1:0] r_r_addr;     // address of the next beat to fetch
    logic [7:0]        r_ar_len;
    logic [2:0]        r_ar_size;
    logic [1:0]        r_ar_burst;
    logic [7:0]        r_r_cnt;      // beat currently presented on R
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [ID_W-1:0]   r_rid;

    // memory access wires
    logic [MEM_AW-1:0] w_wr_word;
    logic              w_wr_oor;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [MEM_AW-1:0] w_rd_word;
    logic              w_rd_oor;
    logic              w_rd_load;
    logic [DATA_W-1:0] w_rdata;

    // wready/arready are only ever high in W_DATA/R_IDLE, so the
    // handshakes already imply the state.
    assign w_aw_hs = bus.awvalid && r_awready;
    assign w_w_hs  = bus.wvalid  && r_wready;
    assign w_b_hs  = r_bvalid    && bus.bready;
    assign w_ar_hs = bus.arvalid && r_arready;
    assign w_r_hs  = r_rvalid    && bus.rready;

    assign w_wr_word = r_w_addr[MEM_AW+BSH-1:BSH];
    assign w_mem_we  = w_w_hs && !w_wr_oor;

    // Beat 0 is fetched straight from araddr on the AR handshake; later
    // beats come from the precomputed next address on each R handshake
    // that is not the last one.
    assign w_rd_addr = (r_r_state == R_IDLE) ? bus.araddr : r_r_addr;
    assign w_rd_word = w_rd_addr[MEM_AW+BSH-1:BSH];
    assign w_rd_load = w_ar_hs || (w_r_hs && (r_r_cnt != r_ar_len));

`ifdef AXI_SLV_MEM_OOR_ERR_EN
    assign w_wr_oor = |r_w_addr[ADDR_W-1:MEM_AW+BSH];
    assign w_rd_oor = |w_rd_addr[ADDR_W-1:MEM_AW+BSH];
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    // ------------------------------------------------------------------
    // write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_w_state  <= W_IDLE;
            r_w_addr   <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= '0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_w_addr   <= bus.awaddr;
                        r_aw_len   <= bus.awlen;
                        r_aw_size  <= bus.awsize;
                        r_aw_burst <= bus.awburst;
                        r_bid      <= bus.awid;
                        r_w_cnt    <= '0;
                        r_w_err    <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_w_addr <= next_addr(r_w_addr, r_aw_len, r_aw_size, r_aw_burst);
                        r_w_cnt  <= r_w_cnt + 8'd1;
                        // beat count, not wlast, ends the burst
                        if (r_w_cnt == r_aw_len) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bresp   <= (r_w_err || w_wr_oor) ? RESP_SLVERR : RESP_OKAY;
                            r_w_state <= W_RESP;
                        end else begin
                            r_w_err <= r_w_err || w_wr_oor;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: begin
                    r_bvalid  <= 1'b0;
                    r_wready  <= 1'b0;
                    r_awready <= 1'b1;
                    r_w_state <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_r_state  <= R_IDLE;
            r_r_addr   <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_r_cnt    <= '0;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rid      <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_r_addr   <= next_addr(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
                        r_ar_len   <= bus.arlen;
                        r_ar_size  <= bus.arsize;
                        r_ar_burst <= bus.arburst;
                        r_rid      <= bus.arid;
                        r_r_cnt    <= '0;
                        r_rlast    <= (bus.arlen == 8'd0);
                        r_rresp    <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    // without a handshake every R output simply holds
                    if (w_r_hs) begin
                        if (r_r_cnt == r_ar_len) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_r_addr <= next_addr(r_r_addr, r_ar_len, r_ar_size, r_ar_burst);
                            r_r_cnt  <= r_r_cnt + 8'd1;
                            r_rlast  <= ((r_r_cnt + 8'd1) == r_ar_len);
                            r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_r_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // storage: one byte-wide array per lane so wstrb maps to a lane enable.
    // The read register samples the array with non-blocking semantics, so a
    // read and write to the same word on one edge returns the old data.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd_byte;

            always_ff @(posedge pll_core_cpuclk) begin
                if (w_mem_we && bus.wstrb[gi]) begin
                    r_mem[w_wr_word] <= bus.wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
                if (!pad_cpu_rst_b) begin
                    r_rd_byte <= 8'h00;
                end else if (w_rd_load) begin
                    r_rd_byte <= w_rd_oor ? 8'h00 : r_mem[w_rd_word];
                end
            end

            assign w_rdata[gi*8 +: 8] = r_rd_byte;
        end
    endgenerate

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.awready = r_awready;
    assign bus.wready  = r_wready;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.bid     = r_bid;
    assign bus.arready = r_arready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rlast   = r_rlast;
    assign bus.rresp   = r_rresp;
    assign bus.rid     = r_rid;
    assign bus.rdata   = w_rdata;

    // Inputs carried for protocol completeness but not acted upon; the upper
    // read-address bits only matter when range checking is enabled.
    logic w_unused;
    assign w_unused = ^{bus.wid, bus.wlast, bus.awcache, bus.awprot,
                        bus.arcache, bus.arprot, w_rd_addr};

endmodule
